// File: rtl/fifo_wr_framer_pkg.sv
// Shared types for the write-side FIFO framer: FSM states and counter sizing.
package fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    TRL,
    DRAIN
  } state_e;

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEF_MAX_LEN = 16;
  localparam int CNT_W       = cnt_width(DEF_MAX_LEN);

endpackage

// File: rtl/fifo_wr_framer_if.sv
// Payload stream in, FIFO write port out; slave is the framer's view.
interface fifo_wr_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  wfull;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;

  modport slave (
    input  s_valid, s_data, s_last, wfull,
    output s_ready, wr_en, wdata
  );

  modport master (
    output s_valid, s_data, s_last, wfull,
    input  s_ready, wr_en, wdata
  );
endinterface

// File: rtl/fifo_wr_framer.sv
// Frames a payload stream into FIFO writes: header(seq), payload, trailer(xor csum).
module fifo_wr_framer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = DEF_MAX_LEN
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  fifo_wr_framer_if.slave       bus,
  output logic [DATA_WIDTH-1:0] seq,
  output logic                  frame_done,
  output logic                  trunc_err
);

  localparam int CW = cnt_width(MAX_LEN);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] seq_q, seq_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  trunc_q, trunc_d;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // Outputs are combinational so an accepted word is written in the same cycle.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    trunc_d     = trunc_q;
    bus.s_ready = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wdata   = '0;
    frame_done  = 1'b0;
    trunc_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_valid) state_d = HDR;
      end
      HDR: begin
        bus.wr_en = !bus.wfull;
        bus.wdata = seq_q;
        if (!bus.wfull) begin
          state_d = PAYLOAD;
          csum_d  = '0;
          cnt_d   = '0;
          seq_d   = seq_q + DATA_WIDTH'(1);
        end
      end
      PAYLOAD: begin
        bus.s_ready = !bus.wfull;
        bus.wr_en   = bus.s_valid && !bus.wfull;
        bus.wdata   = bus.s_data;
        if (bus.s_valid && !bus.wfull) begin
          csum_d = csum_q ^ bus.s_data;
          cnt_d  = cnt_q + CW'(1);
          if (bus.s_last) begin
            state_d = TRL;
          end else if (cnt_q == CW'(MAX_LEN - 1)) begin
            trunc_d = 1'b1;
            state_d = TRL;
          end
        end
      end
      TRL: begin
        bus.wr_en = !bus.wfull;
        bus.wdata = csum_q;
        if (!bus.wfull) begin
          frame_done = 1'b1;
          trunc_err  = trunc_q;
          state_d    = trunc_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        // Excess beats of a truncated frame are swallowed, never written.
        bus.s_ready = 1'b1;
        if (bus.s_valid && bus.s_last) begin
          trunc_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign seq = seq_q;

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Directed vector table plus hand sequences for reset, wrap and mid-frame reset.
module tb_fifo_wr_framer;
  import fifo_pkg::*;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic [7:0] seq;
  logic       frame_done, trunc_err;
  int         total = 0;
  int         bad   = 0;

  fifo_wr_framer_if #(.DATA_WIDTH(8)) bus ();

  fifo_wr_framer #(.DATA_WIDTH(8), .MAX_LEN(4)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .bus        (bus),
    .seq        (seq),
    .frame_done (frame_done),
    .trunc_err  (trunc_err)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       f;
    logic       we;
    logic [7:0] wd;
    logic       rdy;
    logic       fd;
    logic       te;
  } vec_t;

  localparam int NV = 36;
  vec_t vt[NV];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic f,
                              input logic we, input logic [7:0] wd, input logic rdy,
                              input logic fd, input logic te);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.f = f;
    r.we = we; r.wd = wd; r.rdy = rdy; r.fd = fd; r.te = te;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic f);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.wfull   = f;
  endtask

  // Single-word frame from IDLE: bubble, header, word, trailer (= word).
  task automatic do_frame1(input logic [7:0] w, input logic [7:0] hdr, input string nm);
    @(negedge wclk); drive(1'b1, w, 1'b1, 1'b0); #1;
    chk({nm, ".idle_we"}, bus.wr_en, 1'b0);
    @(negedge wclk); #1;
    chk({nm, ".hdr_we"}, bus.wr_en, 1'b1);
    chk({nm, ".hdr"}, bus.wdata, hdr);
    @(negedge wclk); #1;
    chk({nm, ".pay_we"}, bus.wr_en, 1'b1);
    chk({nm, ".pay"}, bus.wdata, w);
    @(negedge wclk); drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk({nm, ".trl"}, bus.wdata, w);
    chk({nm, ".trl_fd"}, {bus.wr_en, frame_done, trunc_err}, 3'b110);
  endtask

  initial begin
    // single frame 11,22,33
    vt[0]  = mk(1, 8'h11, 0, 0,  0, 8'h00, 0, 0, 0);
    vt[1]  = mk(1, 8'h11, 0, 0,  1, 8'h00, 0, 0, 0);
    vt[2]  = mk(1, 8'h11, 0, 0,  1, 8'h11, 1, 0, 0);
    vt[3]  = mk(1, 8'h22, 0, 0,  1, 8'h22, 1, 0, 0);
    vt[4]  = mk(1, 8'h33, 1, 0,  1, 8'h33, 1, 0, 0);
    vt[5]  = mk(0, 8'h00, 0, 0,  1, 8'h00, 0, 1, 0);
    vt[6]  = mk(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    // same frame under backpressure
    vt[7]  = mk(1, 8'h11, 0, 0,  0, 8'h00, 0, 0, 0);
    vt[8]  = mk(1, 8'h11, 0, 0,  1, 8'h01, 0, 0, 0);
    vt[9]  = mk(1, 8'h11, 0, 1,  0, 8'h00, 0, 0, 0);
    vt[10] = mk(1, 8'h11, 0, 1,  0, 8'h00, 0, 0, 0);
    vt[11] = mk(1, 8'h11, 0, 1,  0, 8'h00, 0, 0, 0);
    vt[12] = mk(1, 8'h11, 0, 0,  1, 8'h11, 1, 0, 0);
    vt[13] = mk(1, 8'h22, 0, 0,  1, 8'h22, 1, 0, 0);
    vt[14] = mk(1, 8'h33, 1, 0,  1, 8'h33, 1, 0, 0);
    vt[15] = mk(0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0);
    vt[16] = mk(0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0);
    vt[17] = mk(0, 8'h00, 0, 0,  1, 8'h00, 0, 1, 0);
    // truncation: 01..06, MAX_LEN=4
    vt[18] = mk(1, 8'h01, 0, 0,  0, 8'h00, 0, 0, 0);
    vt[19] = mk(1, 8'h01, 0, 0,  1, 8'h02, 0, 0, 0);
    vt[20] = mk(1, 8'h01, 0, 0,  1, 8'h01, 1, 0, 0);
    vt[21] = mk(1, 8'h02, 0, 0,  1, 8'h02, 1, 0, 0);
    vt[22] = mk(1, 8'h03, 0, 0,  1, 8'h03, 1, 0, 0);
    vt[23] = mk(1, 8'h04, 0, 0,  1, 8'h04, 1, 0, 0);
    vt[24] = mk(1, 8'h05, 0, 0,  1, 8'h04, 0, 1, 1);
    vt[25] = mk(1, 8'h05, 0, 0,  0, 8'h00, 1, 0, 0);
    vt[26] = mk(1, 8'h06, 1, 0,  0, 8'h00, 1, 0, 0);
    vt[27] = mk(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);
    // exact MAX_LEN frame A0..A3
    vt[28] = mk(1, 8'hA0, 0, 0,  0, 8'h00, 0, 0, 0);
    vt[29] = mk(1, 8'hA0, 0, 0,  1, 8'h03, 0, 0, 0);
    vt[30] = mk(1, 8'hA0, 0, 0,  1, 8'hA0, 1, 0, 0);
    vt[31] = mk(1, 8'hA1, 0, 0,  1, 8'hA1, 1, 0, 0);
    vt[32] = mk(1, 8'hA2, 0, 0,  1, 8'hA2, 1, 0, 0);
    vt[33] = mk(1, 8'hA3, 1, 0,  1, 8'hA3, 1, 0, 0);
    vt[34] = mk(0, 8'h00, 0, 0,  1, 8'h00, 0, 1, 0);
    vt[35] = mk(0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0);

    wrst_n = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    #3;
    chk("rst.outs", {bus.wr_en, bus.s_ready, frame_done, trunc_err}, 4'b0000);
    chk("rst.seq", seq, 8'h00);
    @(negedge wclk); drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge wclk); wrst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge wclk); drive(vt[i].v, vt[i].d, vt[i].l, vt[i].f); #1;
      chk($sformatf("vec%0d.we", i), bus.wr_en, vt[i].we);
      chk($sformatf("vec%0d.rdy", i), bus.s_ready, vt[i].rdy);
      chk($sformatf("vec%0d.fd", i), frame_done, vt[i].fd);
      chk($sformatf("vec%0d.te", i), trunc_err, vt[i].te);
      if (vt[i].we) chk($sformatf("vec%0d.wd", i), bus.wdata, vt[i].wd);
    end
    chk("seq.after4", seq, 8'h04);

    // reset after header + 2 payload words
    @(negedge wclk); drive(1'b1, 8'h10, 1'b0, 1'b0);
    @(negedge wclk); #1; chk("mid.hdr", bus.wdata, 8'h04);
    @(negedge wclk); #1; chk("mid.p0", bus.wdata, 8'h10);
    @(negedge wclk); drive(1'b1, 8'h20, 1'b0, 1'b0); #1; chk("mid.p1", bus.wdata, 8'h20);
    @(negedge wclk); drive(1'b1, 8'h30, 1'b0, 1'b0); #1;
    chk("mid.pre_rst_rdy", bus.s_ready, 1'b1);
    wrst_n = 1'b0; #1;
    chk("mid.rst_outs", {bus.wr_en, bus.s_ready, frame_done}, 3'b000);
    @(negedge wclk); drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge wclk); wrst_n = 1'b1;
    do_frame1(8'h5A, 8'h00, "post_rst");
    chk("post_rst.seq", seq, 8'h01);

    // sequence wrap from a fresh reset
    @(negedge wclk); wrst_n = 1'b0;
    @(negedge wclk); wrst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      logic [7:0] w;
      w = 8'(i * 3 + 1);
      do_frame1(w, 8'(i), $sformatf("wrap%0d", i));
    end
    chk("wrap.seq", seq, 8'h01);

    @(negedge wclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
